ysyx_25010008_axi_arbiter: RTL and testbench
============================================

# ysyx_25010008_axi_arbiter

- Two-master, one-slave AXI4-Lite arbiter that shares the single memory/MMIO port between IFU (master 0) and LSU (master 1).
- Grants one whole transaction at a time, from the address handshake through the final R or B handshake, then re-arbitrates.
- Forwards the granted master's channels combinationally to the slave and gates every other master-side handshake to zero.
- Sits between the core's fetch/load-store units and the xbar/SRAM model.

## Interface
- `ADDR_W`, default 32, address width.
- `DATA_W`, default 32, data width; `wstrb` is `DATA_W/8` bits.

Ports. Signals are listed in order; each group applies to N ∈ {0,1}.
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mN_araddr`/`mN_arvalid`/`mN_arready`  in/in/out  ADDR_W/1/1  read-address channel.
- `mN_rdata`/`mN_rresp`/`mN_rvalid`/`mN_rready`  out/out/out/in  DATA_W/2/1/1  read-data channel.
- `mN_awaddr`/`mN_awvalid`/`mN_awready`  in/in/out  ADDR_W/1/1  write-address channel.
- `mN_wdata`/`mN_wstrb`/`mN_wvalid`/`mN_wready`  in/in/in/out  DATA_W/DATA_W/8/1/1  write-data channel.
- `mN_bresp`/`mN_bvalid`/`mN_bready`  out/out/in  2/1/1  write-response channel.
- `s_*`: same five channels, mirrored directions, toward the slave.
- `grant`  out  2  one-hot owner (bit0 = m0, bit1 = m1); 0 when idle.
- `busy`  out  1  transaction in flight.

## Operation
- States:
  - IDLE
  - RD_ADDR → RD_DATA
  - WR_ADDR → WR_DATA → WR_RESP
- Registers: `state`, `owner` (1 bit), `last` (last-granted master).
- IDLE:
  - A master requests when its `arvalid` or `awvalid` is high.
  - Choose a winner (see Configuration). Register `owner` and move to WR_ADDR if the winner's `awvalid` is high, else RD_ADDR.
  - Within one master, write beats read.
  - No request: stay in IDLE.
- RD_ADDR: forward `owner`'s AR to `s_`. On `s_arvalid && s_arready`, go to RD_DATA.
- RD_DATA: forward `s_r*` to `owner` and `owner`'s `rready` to the slave. On `s_rvalid && s_rready`, set `last <= owner` and go to IDLE.
- WR_ADDR: forward AW. On handshake, go to WR_DATA.
- WR_DATA: forward W. On handshake, go to WR_RESP.
- WR_RESP: forward B. On handshake, set `last <= owner` and go to IDLE.
- Gating: only the channel of the current state is forwarded.
  - All other `s_*valid`/`s_*ready` and all non-owner `mN_*ready`/`mN_*valid` outputs are 0.
  - Data/addr/resp outputs are don't-care when not gated in; drive 0.
- `grant` = one-hot(`owner`) when `state != IDLE`; `busy = (state != IDLE)`.
- Responses (`rresp`, `bresp`) pass through unmodified, including error codes.
- A master that drops its valid before being granted is simply not granted; arbitration re-evaluates every IDLE cycle.

## Timing
- Reset asserted, at any time including mid-transaction:
  - Immediately sets `state=IDLE`, `owner=0`, `last=1`.
  - All valid/ready outputs, `grant` and `busy` read 0 on the same cycle.
  - The in-flight transaction is abandoned.
- Arbitration latency: a request seen in IDLE at edge k is forwarded to the slave from cycle k+1. Minimum 1 idle cycle between back-to-back transactions.
- Read with a zero-wait slave: 3 cycles from request to `rvalid` handshake (IDLE, RD_ADDR, RD_DATA).
- Write with a zero-wait slave: 4 cycles (IDLE, WR_ADDR, WR_DATA, WR_RESP).
- No combinational path from any `mN_*valid` to `s_*` outside the granted state. Forwarding within a state is purely combinational (0 added cycles per handshake).
- The slave may stall indefinitely; the arbiter holds state and ownership.
- The non-owner's valid is held pending, never lost.
- Simultaneous m0/m1 requests in IDLE are resolved by the policy; the loser is served in the immediately following transaction if it is still requesting.

## Configuration
- `YSYX_ARB_RR_EN` defined: round-robin. On a tie, grant the master ≠ `last`; a single requester always wins.
- `YSYX_ARB_RR_EN` undefined: fixed priority, m1 (LSU) always beats m0 (IFU). `last` is still maintained but not used.

## Test plan
- Single read: m0 reads 0x8000_0000 and the slave returns 0xDEADBEEF with OKAY.
  - Required: `m0_rdata=0xDEADBEEF` on the 3rd cycle; `grant=01`.
  - Required: `m1_arready` stays 0 throughout.
- Simultaneous reads, both masters requesting every cycle, 4 transactions:
  - With `YSYX_ARB_RR_EN`: grants alternate m0, m1, m0, m1 (`last=1` after reset).
  - Without it: m1 wins all 4; m0 is served only once m1 drops `arvalid`.
- Write path: m1 writes 0x1000_0000, `wdata=0x41`, `wstrb=0001`; the slave stalls `awready` 5 cycles and `bvalid` 3 cycles.
  - Required: AW, then W, then B forwarded in order; `busy` stays high.
  - Required: a pending m0 read is not granted until the B handshake.
- Same-master read+write: m1 raises `arvalid` and `awvalid` together.
  - Required: the write is granted first (state goes to WR_ADDR); the read follows next.
- Error pass-through: the slave returns `rresp=2'b10` to m0.
  - Required: `m0_rresp=2'b10` unchanged; the arbiter returns to IDLE normally.
- Reset mid-op: assert `reset` low in RD_DATA while `s_rvalid=0`.
  - Required: `busy`, `grant`, and all valid/ready outputs are 0 before the next edge.
  - Required: after release, a new m0 read completes normally.

Source files
------------

// File: rtl/ysyx_25010008_axi_arbiter_if.sv
// AXI4-Lite bundle shared by the arbiter's two master ports and its slave port.
// "master" drives requests; "slave" answers them.
interface ysyx_25010008_axi_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();

  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;

  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;

  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output araddr, arvalid, input  arready,
    input  rdata, rresp, rvalid, output rready,
    output awaddr, awvalid, input  awready,
    output wdata, wstrb, wvalid, input  wready,
    input  bresp, bvalid, output bready
  );

  modport slave (
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input  rready,
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input  bready
  );

endinterface

// File: rtl/ysyx_25010008_axi_arbiter.sv
// Two-master (IFU=m0, LSU=m1) to one-slave AXI4-Lite arbiter, one whole transaction per grant.
// Define YSYX_ARB_RR_EN for round-robin arbitration; otherwise m1 has fixed priority.
module ysyx_25010008_axi_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  ysyx_25010008_axi_if.slave   m0,
  ysyx_25010008_axi_if.slave   m1,
  ysyx_25010008_axi_if.master  s,
  output logic [1:0]           grant,
  output logic                 busy
);

  typedef enum logic [2:0] {
    StIdle,
    StRdAddr,
    StRdData,
    StWrAddr,
    StWrData,
    StWrResp
  } state_e;

  state_e r_state;
  state_e w_state_nxt;
  logic   r_owner;
  logic   w_owner_nxt;
  logic   r_last;
  logic   w_last_nxt;

  logic   w_req0;
  logic   w_req1;
  logic   w_win;
  logic   w_win_aw;

  // Request side of the current owner
  logic [ADDR_W-1:0]   w_araddr;
  logic                w_arvalid;
  logic                w_rready;
  logic [ADDR_W-1:0]   w_awaddr;
  logic                w_awvalid;
  logic [DATA_W-1:0]   w_wdata;
  logic [DATA_W/8-1:0] w_wstrb;
  logic                w_wvalid;
  logic                w_bready;

  // Response side destined for the current owner
  logic                w_arready;
  logic [DATA_W-1:0]   w_rdata;
  logic [1:0]          w_rresp;
  logic                w_rvalid;
  logic                w_awready;
  logic                w_wready;
  logic [1:0]          w_bresp;
  logic                w_bvalid;

  assign w_req0 = m0.arvalid | m0.awvalid;
  assign w_req1 = m1.arvalid | m1.awvalid;

`ifdef YSYX_ARB_RR_EN
  assign w_win = (w_req0 && w_req1) ? ~r_last : w_req1;
`else
  assign w_win = w_req1;
`endif

  assign w_win_aw = w_win ? m1.awvalid : m0.awvalid;

  assign w_araddr  = r_owner ? m1.araddr  : m0.araddr;
  assign w_arvalid = r_owner ? m1.arvalid : m0.arvalid;
  assign w_rready  = r_owner ? m1.rready  : m0.rready;
  assign w_awaddr  = r_owner ? m1.awaddr  : m0.awaddr;
  assign w_awvalid = r_owner ? m1.awvalid : m0.awvalid;
  assign w_wdata   = r_owner ? m1.wdata   : m0.wdata;
  assign w_wstrb   = r_owner ? m1.wstrb   : m0.wstrb;
  assign w_wvalid  = r_owner ? m1.wvalid  : m0.wvalid;
  assign w_bready  = r_owner ? m1.bready  : m0.bready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= StIdle;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    unique case (r_state)
      StIdle: begin
        if (w_req0 || w_req1) begin
          w_owner_nxt = w_win;
          // Within one master a pending write goes ahead of a pending read
          w_state_nxt = w_win_aw ? StWrAddr : StRdAddr;
        end
      end
      StRdAddr: begin
        if (w_arvalid && s.arready) w_state_nxt = StRdData;
      end
      StRdData: begin
        if (s.rvalid && w_rready) begin
          w_last_nxt  = r_owner;
          w_state_nxt = StIdle;
        end
      end
      StWrAddr: begin
        if (w_awvalid && s.awready) w_state_nxt = StWrData;
      end
      StWrData: begin
        if (w_wvalid && s.wready) w_state_nxt = StWrResp;
      end
      StWrResp: begin
        if (s.bvalid && w_bready) begin
          w_last_nxt  = r_owner;
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Only the channel belonging to the current state is opened; everything else reads 0
  always_comb begin
    s.araddr  = '0;
    s.arvalid = 1'b0;
    s.rready  = 1'b0;
    s.awaddr  = '0;
    s.awvalid = 1'b0;
    s.wdata   = '0;
    s.wstrb   = '0;
    s.wvalid  = 1'b0;
    s.bready  = 1'b0;
    w_arready = 1'b0;
    w_rdata   = '0;
    w_rresp   = 2'b00;
    w_rvalid  = 1'b0;
    w_awready = 1'b0;
    w_wready  = 1'b0;
    w_bresp   = 2'b00;
    w_bvalid  = 1'b0;
    unique case (r_state)
      StRdAddr: begin
        s.araddr  = w_araddr;
        s.arvalid = w_arvalid;
        w_arready = s.arready;
      end
      StRdData: begin
        w_rdata  = s.rdata;
        w_rresp  = s.rresp;
        w_rvalid = s.rvalid;
        s.rready = w_rready;
      end
      StWrAddr: begin
        s.awaddr  = w_awaddr;
        s.awvalid = w_awvalid;
        w_awready = s.awready;
      end
      StWrData: begin
        s.wdata  = w_wdata;
        s.wstrb  = w_wstrb;
        s.wvalid = w_wvalid;
        w_wready = s.wready;
      end
      StWrResp: begin
        w_bresp  = s.bresp;
        w_bvalid = s.bvalid;
        s.bready = w_bready;
      end
      default: ;
    endcase
  end

  always_comb begin
    m0.arready = 1'b0;
    m0.rdata   = '0;
    m0.rresp   = 2'b00;
    m0.rvalid  = 1'b0;
    m0.awready = 1'b0;
    m0.wready  = 1'b0;
    m0.bresp   = 2'b00;
    m0.bvalid  = 1'b0;
    m1.arready = 1'b0;
    m1.rdata   = '0;
    m1.rresp   = 2'b00;
    m1.rvalid  = 1'b0;
    m1.awready = 1'b0;
    m1.wready  = 1'b0;
    m1.bresp   = 2'b00;
    m1.bvalid  = 1'b0;
    if (r_owner) begin
      m1.arready = w_arready;
      m1.rdata   = w_rdata;
      m1.rresp   = w_rresp;
      m1.rvalid  = w_rvalid;
      m1.awready = w_awready;
      m1.wready  = w_wready;
      m1.bresp   = w_bresp;
      m1.bvalid  = w_bvalid;
    end else begin
      m0.arready = w_arready;
      m0.rdata   = w_rdata;
      m0.rresp   = w_rresp;
      m0.rvalid  = w_rvalid;
      m0.awready = w_awready;
      m0.wready  = w_wready;
      m0.bresp   = w_bresp;
      m0.bvalid  = w_bvalid;
    end
  end

  assign busy  = (r_state != StIdle);
  assign grant = busy ? {r_owner, ~r_owner} : 2'b00;

endmodule

// File: tb/tb_ysyx_25010008_axi_arbiter.sv
// Scoreboard bench for the two-master AXI4-Lite arbiter: master/slave bus models plus
// expected-read, expected-write and expected-grant queues.
`timescale 1ns/1ps
module tb_ysyx_25010008_axi_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] grant;
  logic       busy;

  always #5 clock = ~clock;

  ysyx_25010008_axi_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
  ysyx_25010008_axi_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();
  ysyx_25010008_axi_if #(.ADDR_W(32), .DATA_W(32)) s_if ();

  ysyx_25010008_axi_arbiter #(.ADDR_W(32), .DATA_W(32)) u_dut (
    .clock (clock),
    .reset (reset),
    .m0    (m0_if),
    .m1    (m1_if),
    .s     (s_if),
    .grant (grant),
    .busy  (busy)
  );

  // Master-side drive and observe
  logic [31:0] m_araddr[2], m_awaddr[2], m_wdata[2], m_rdata[2];
  logic [3:0]  m_wstrb[2];
  logic [1:0]  m_rresp[2], m_bresp[2];
  logic        m_arvalid[2], m_rready[2], m_awvalid[2], m_wvalid[2], m_bready[2];
  logic        m_arready[2], m_rvalid[2], m_awready[2], m_wready[2], m_bvalid[2];

  assign m0_if.araddr  = m_araddr[0];
  assign m0_if.arvalid = m_arvalid[0];
  assign m0_if.rready  = m_rready[0];
  assign m0_if.awaddr  = m_awaddr[0];
  assign m0_if.awvalid = m_awvalid[0];
  assign m0_if.wdata   = m_wdata[0];
  assign m0_if.wstrb   = m_wstrb[0];
  assign m0_if.wvalid  = m_wvalid[0];
  assign m0_if.bready  = m_bready[0];
  assign m_arready[0]  = m0_if.arready;
  assign m_rdata[0]    = m0_if.rdata;
  assign m_rresp[0]    = m0_if.rresp;
  assign m_rvalid[0]   = m0_if.rvalid;
  assign m_awready[0]  = m0_if.awready;
  assign m_wready[0]   = m0_if.wready;
  assign m_bresp[0]    = m0_if.bresp;
  assign m_bvalid[0]   = m0_if.bvalid;

  assign m1_if.araddr  = m_araddr[1];
  assign m1_if.arvalid = m_arvalid[1];
  assign m1_if.rready  = m_rready[1];
  assign m1_if.awaddr  = m_awaddr[1];
  assign m1_if.awvalid = m_awvalid[1];
  assign m1_if.wdata   = m_wdata[1];
  assign m1_if.wstrb   = m_wstrb[1];
  assign m1_if.wvalid  = m_wvalid[1];
  assign m1_if.bready  = m_bready[1];
  assign m_arready[1]  = m1_if.arready;
  assign m_rdata[1]    = m1_if.rdata;
  assign m_rresp[1]    = m1_if.rresp;
  assign m_rvalid[1]   = m1_if.rvalid;
  assign m_awready[1]  = m1_if.awready;
  assign m_wready[1]   = m1_if.wready;
  assign m_bresp[1]    = m1_if.bresp;
  assign m_bvalid[1]   = m1_if.bvalid;

  // Slave-side drive
  logic        s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp, s_bresp;

  assign s_if.arready = s_arready;
  assign s_if.rdata   = s_rdata;
  assign s_if.rresp   = s_rresp;
  assign s_if.rvalid  = s_rvalid;
  assign s_if.awready = s_awready;
  assign s_if.wready  = s_wready;
  assign s_if.bresp   = s_bresp;
  assign s_if.bvalid  = s_bvalid;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } wreq_t;

  logic [31:0] rd_q[2][$];
  wreq_t       wr_q[2][$];
  logic [33:0] exp_rd[2][$];
  wreq_t       exp_wr[2][$];
  logic [1:0]  exp_b[2][$];
  logic [3:0]  exp_grant[$];  // {grant, awvalid, arvalid} on the first granted cycle

  int   r_st[2], w_st[2], rd_lat[2], last_lat[2];
  logic aw_done[2], w_done[2];
  logic hs_ar[2], hs_r[2], hs_aw[2], hs_w[2], hs_b[2];
  logic hs_sar, hs_sr, hs_saw, hs_sw, hs_sb, sv_arvalid, sv_awvalid, sv_wvalid;
  logic [31:0] sar_addr, saw_addr;
  logic aw_seen, r_pend, b_pend;
  int   ar_stall, r_stall, aw_stall, w_stall, b_stall;
  int   ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
  logic [1:0] prev_grant;
  int   gate_err;
  int   n_checks, n_errors;

  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    return (a == 32'h8000_0000) ? 32'hDEAD_BEEF : (a ^ 32'h1357_9BDF);
  endfunction

  function automatic logic [1:0] resp_of(input logic [31:0] a);
    return (a[31:28] == 4'hF) ? 2'b10 : 2'b00;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_sample();
    int own;
    logic [33:0] e;
    wreq_t w;
    own = grant[1] ? 1 : 0;
    for (int m = 0; m < 2; m++) begin
      hs_ar[m] = m_arvalid[m] && m_arready[m];
      hs_r[m]  = m_rvalid[m]  && m_rready[m];
      hs_aw[m] = m_awvalid[m] && m_awready[m];
      hs_w[m]  = m_wvalid[m]  && m_wready[m];
      hs_b[m]  = m_bvalid[m]  && m_bready[m];
      if (!grant[m] && (m_arready[m] || m_rvalid[m] || m_awready[m] || m_wready[m] ||
                        m_bvalid[m])) gate_err++;
      if (r_st[m] != 0) rd_lat[m]++;
      if (hs_r[m]) begin
        last_lat[m] = rd_lat[m];
        if (exp_rd[m].size() == 0) check("rd_unexpected", 64'(m_rdata[m]), 64'(0));
        else begin
          e = exp_rd[m].pop_front();
          check($sformatf("rdata_m%0d", m), 64'(m_rdata[m]), 64'(e[31:0]));
          check($sformatf("rresp_m%0d", m), 64'(m_rresp[m]), 64'(e[33:32]));
        end
      end
      if (hs_b[m]) begin
        if (exp_b[m].size() == 0) check("b_unexpected", 64'(m_bresp[m]), 64'(0));
        else check($sformatf("bresp_m%0d", m), 64'(m_bresp[m]), 64'(exp_b[m].pop_front()));
      end
    end
    sv_arvalid = s_if.arvalid;
    sv_awvalid = s_if.awvalid;
    sv_wvalid  = s_if.wvalid;
    hs_sar = s_if.arvalid && s_arready;
    hs_sr  = s_rvalid && s_if.rready;
    hs_saw = s_if.awvalid && s_awready;
    hs_sw  = s_if.wvalid && s_wready;
    hs_sb  = s_bvalid && s_if.bready;
    if (grant == 2'b00 && (s_if.arvalid || s_if.rready || s_if.awvalid || s_if.wvalid ||
                           s_if.bready)) gate_err++;
    if (hs_sar) sar_addr = s_if.araddr;
    if (hs_saw) begin
      saw_addr = s_if.awaddr;
      aw_seen  = 1'b1;
      if (exp_wr[own].size() == 0) check("aw_unexpected", 64'(s_if.awaddr), 64'(0));
      else check("awaddr", 64'(s_if.awaddr), 64'(exp_wr[own][0].addr));
    end
    if (hs_sw) begin
      check("w_after_aw", 64'(aw_seen), 64'(1));
      aw_seen = 1'b0;
      if (exp_wr[own].size() == 0) check("w_unexpected", 64'(s_if.wdata), 64'(0));
      else begin
        w = exp_wr[own].pop_front();
        check("wdata", 64'(s_if.wdata), 64'(w.data));
        check("wstrb", 64'(s_if.wstrb), 64'(w.strb));
      end
    end
    if (grant != 2'b00 && prev_grant == 2'b00) begin
      if (exp_grant.size() == 0)
        check("grant_unexpected", 64'({grant, s_if.awvalid, s_if.arvalid}), 64'(0));
      else
        check("grant_seq", 64'({grant, s_if.awvalid, s_if.arvalid}), 64'(exp_grant.pop_front()));
    end
    prev_grant = grant;
  endtask

  task automatic model_clear();
    for (int m = 0; m < 2; m++) begin
      m_araddr[m] = '0; m_arvalid[m] = 1'b0; m_rready[m] = 1'b0;
      m_awaddr[m] = '0; m_awvalid[m] = 1'b0; m_wdata[m]  = '0;
      m_wstrb[m]  = '0; m_wvalid[m]  = 1'b0; m_bready[m] = 1'b0;
      r_st[m] = 0; w_st[m] = 0; rd_lat[m] = 0; aw_done[m] = 1'b0; w_done[m] = 1'b0;
      rd_q[m].delete(); wr_q[m].delete(); exp_rd[m].delete(); exp_wr[m].delete();
      exp_b[m].delete();
    end
    exp_grant.delete();
    r_pend = 1'b0; b_pend = 1'b0; aw_seen = 1'b0; prev_grant = 2'b00;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    s_rvalid = 1'b0; s_bvalid = 1'b0; s_rdata = '0; s_rresp = 2'b00; s_bresp = 2'b00;
    s_arready = (ar_stall == 0); s_awready = (aw_stall == 0); s_wready = (w_stall == 0);
  endtask

  task automatic model_update();
    logic [31:0] a;
    wreq_t w;
    if (!reset) begin
      model_clear();
      return;
    end
    for (int m = 0; m < 2; m++) begin
      if (r_st[m] == 1 && hs_ar[m]) begin
        m_arvalid[m] = 1'b0; m_rready[m] = 1'b1; r_st[m] = 2;
      end else if (r_st[m] == 2 && hs_r[m]) begin
        m_rready[m] = 1'b0; r_st[m] = 0;
      end
      if (r_st[m] == 0 && rd_q[m].size() > 0) begin
        a = rd_q[m].pop_front();
        m_araddr[m] = a; m_arvalid[m] = 1'b1; r_st[m] = 1; rd_lat[m] = 0;
        exp_rd[m].push_back({resp_of(a), rdata_of(a)});
      end
      if (w_st[m] == 1) begin
        if (hs_aw[m]) begin m_awvalid[m] = 1'b0; aw_done[m] = 1'b1; end
        if (hs_w[m])  begin m_wvalid[m]  = 1'b0; w_done[m]  = 1'b1; end
        if (aw_done[m] && w_done[m]) begin m_bready[m] = 1'b1; w_st[m] = 2; end
      end else if (w_st[m] == 2 && hs_b[m]) begin
        m_bready[m] = 1'b0; w_st[m] = 0;
      end
      if (w_st[m] == 0 && wr_q[m].size() > 0) begin
        w = wr_q[m].pop_front();
        m_awaddr[m] = w.addr; m_wdata[m] = w.data; m_wstrb[m] = w.strb;
        m_awvalid[m] = 1'b1; m_wvalid[m] = 1'b1; aw_done[m] = 1'b0; w_done[m] = 1'b0;
        w_st[m] = 1;
        exp_wr[m].push_back(w);
        exp_b[m].push_back(resp_of(w.addr));
      end
    end
    // Slave: ready/valid held off by a per-channel stall count
    if (hs_sr) begin r_pend = 1'b0; s_rvalid = 1'b0; end
    if (hs_sar) begin
      ar_cnt = 0; r_pend = 1'b1; r_cnt = 0;
      s_rdata = rdata_of(sar_addr); s_rresp = resp_of(sar_addr);
    end else if (sv_arvalid) ar_cnt++;
    if (r_pend) begin
      if (r_cnt >= r_stall) s_rvalid = 1'b1;
      else r_cnt++;
    end
    if (hs_saw) aw_cnt = 0;
    else if (sv_awvalid) aw_cnt++;
    if (hs_sb) begin b_pend = 1'b0; s_bvalid = 1'b0; end
    if (hs_sw) begin
      w_cnt = 0; b_pend = 1'b1; b_cnt = 0; s_bresp = resp_of(saw_addr);
    end else if (sv_wvalid) w_cnt++;
    if (b_pend) begin
      if (b_cnt >= b_stall) s_bvalid = 1'b1;
      else b_cnt++;
    end
    s_arready = (ar_cnt >= ar_stall);
    s_awready = (aw_cnt >= aw_stall);
    s_wready  = (w_cnt >= w_stall);
  endtask

  function automatic logic all_idle();
    logic ok;
    ok = !busy && !r_pend && !b_pend;
    for (int m = 0; m < 2; m++)
      ok = ok && rd_q[m].size() == 0 && wr_q[m].size() == 0 && r_st[m] == 0 && w_st[m] == 0;
    return ok;
  endfunction

  task automatic step();
    @(posedge clock);
    #3;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (n < budget && !all_idle()) begin
      step();
      n++;
    end
    check(tag, 64'(all_idle()), 64'(1));
    check({tag, "_grants_left"}, 64'(exp_grant.size()), 64'(0));
  endtask

  task automatic check_all_quiet(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_grant"}, 64'(grant), 64'(0));
    check({tag, "_s_vr"}, 64'({s_if.arvalid, s_if.rready, s_if.awvalid, s_if.wvalid,
                               s_if.bready}), 64'(0));
    check({tag, "_m_vr"}, 64'({m_arready[0], m_rvalid[0], m_awready[0], m_wready[0], m_bvalid[0],
                               m_arready[1], m_rvalid[1], m_awready[1], m_wready[1], m_bvalid[1]}),
          64'(0));
  endtask

  initial begin
    int n;
    int bad;
    n_checks = 0; n_errors = 0; gate_err = 0;
    ar_stall = 0; r_stall = 0; aw_stall = 0; w_stall = 0; b_stall = 0;
    for (int m = 0; m < 2; m++) last_lat[m] = 0;
    model_clear();
    hs_sar = 1'b0; hs_sr = 1'b0; hs_saw = 1'b0; hs_sw = 1'b0; hs_sb = 1'b0;
    sv_arvalid = 1'b0; sv_awvalid = 1'b0; sv_wvalid = 1'b0; sar_addr = '0; saw_addr = '0;
    for (int m = 0; m < 2; m++) begin
      hs_ar[m] = 1'b0; hs_r[m] = 1'b0; hs_aw[m] = 1'b0; hs_w[m] = 1'b0; hs_b[m] = 1'b0;
    end
    fork
      forever begin
        @(negedge clock);
        model_sample();
        @(posedge clock);
        #1;
        model_update();
      end
      begin
        #1 reset = 1'b0;
        #1;
        check_all_quiet("reset");
        repeat (3) step();
        reset = 1'b1;
        step();

        // Both masters contend for consecutive reads
`ifdef YSYX_ARB_RR_EN
        rd_q[0].push_back(32'h8000_0100); rd_q[0].push_back(32'h8000_0108);
        rd_q[1].push_back(32'h2000_0000); rd_q[1].push_back(32'h2000_0004);
        exp_grant.push_back(4'b0101); exp_grant.push_back(4'b1001);
        exp_grant.push_back(4'b0101); exp_grant.push_back(4'b1001);
`else
        for (int i = 0; i < 4; i++) rd_q[1].push_back(32'h2000_0000 + 32'(i * 4));
        rd_q[0].push_back(32'h8000_0100);
        for (int i = 0; i < 4; i++) exp_grant.push_back(4'b1001);
        exp_grant.push_back(4'b0101);
`endif
        wait_idle("contend_done", 200);

        // Single m0 read, zero-wait slave
        rd_q[0].push_back(32'h8000_0000);
        exp_grant.push_back(4'b0101);
        wait_idle("single_rd_done", 50);
        check("single_rd_latency", 64'(last_lat[0]), 64'(3));
        check("single_rd_gating", 64'(gate_err), 64'(0));

        // m1 write against a stalling slave with an m0 read waiting behind it
        aw_stall = 5; b_stall = 3;
        wr_q[1].push_back('{addr: 32'h1000_0000, data: 32'h41, strb: 4'b0001});
        exp_grant.push_back(4'b1010);
        n = 0;
        while (grant != 2'b10 && n < 20) begin step(); n++; end
        check("wr_granted", 64'(grant), 64'(2'b10));
        rd_q[0].push_back(32'h8000_0004);
        exp_grant.push_back(4'b0101);
        n = 0; bad = 0;
        while (grant == 2'b10 && n < 60) begin
          if (!busy || m_arready[0] || m_rvalid[0]) bad++;
          step();
          n++;
        end
        check("wr_hold_busy", 64'(bad), 64'(0));
        check("wr_stall_respected", 64'(n >= 9), 64'(1));
        wait_idle("wr_done", 60);
        aw_stall = 0; b_stall = 0;

        // Same master raises read and write together: write first
        wr_q[1].push_back('{addr: 32'h1000_0010, data: 32'hCAFE_F00D, strb: 4'b1111});
        rd_q[1].push_back(32'h3000_0000);
        exp_grant.push_back(4'b1010); exp_grant.push_back(4'b1001);
        wait_idle("same_master_done", 60);

        // Error responses on both read and write pass through untouched
        rd_q[0].push_back(32'hF000_0010);
        wr_q[0].push_back('{addr: 32'hF000_0020, data: 32'h5555_AAAA, strb: 4'b0110});
        exp_grant.push_back(4'b0110); exp_grant.push_back(4'b0101);
        wait_idle("err_done", 60);

        // Reset while the slave withholds rvalid
        r_stall = 1000;
        rd_q[0].push_back(32'h8000_0000);
        exp_grant.push_back(4'b0101);
        n = 0;
        while (!(grant == 2'b01 && s_if.rready && !s_rvalid) && n < 20) begin step(); n++; end
        check("mid_rd_reached", 64'(grant == 2'b01 && s_if.rready && !s_rvalid), 64'(1));
        reset = 1'b0;
        #1;
        check_all_quiet("mid_reset");
        r_stall = 0;
        repeat (2) step();
        reset = 1'b1;
        step();
        rd_q[0].push_back(32'h8000_0000);
        exp_grant.push_back(4'b0101);
        wait_idle("post_reset_rd_done", 50);
        check("post_reset_rd_latency", 64'(last_lat[0]), 64'(3));
        check("gating_total", 64'(gate_err), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
      end
      begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
      end
    join_any
  end

endmodule
